// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between eight val/rdy requesters, the arbiter and the
// downstream consumer. The arbiter takes the slave view.
interface mux8_rr_arbiter_if #(
    parameter int p_nbits = 32
);
    logic [7:0]           in_val;
    logic [7:0]           in_rdy;
    logic [8*p_nbits-1:0] in_msg;
    logic                 out_val;
    logic                 out_rdy;
    logic [p_nbits-1:0]   out_msg;
    logic [2:0]           out_src;
    logic [2:0]           grant_sel;

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_src, grant_sel
    );

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_src, grant_sel
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 message mux among eight requesters,
// feeding a single-entry registered output buffer.
module mux8_rr_arbiter #(
    parameter int p_nbits = 32
) (
    input logic              clk,
    input logic              rst,
    mux8_rr_arbiter_if.slave bus
);
    localparam int NUM_LANES = 8;

    logic [NUM_LANES-1:0][p_nbits-1:0] slots;
    logic [2:0]                        ptr;
    logic [2:0]                        sel;
    logic                              val_q;
    logic [p_nbits-1:0]                msg_q;
    logic [2:0]                        src_q;
    logic                              can_accept;

    assign slots = bus.in_msg;

    // Scan from ptr upward with wrap; with nothing valid the select parks on ptr.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        sel   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = ptr + 3'(k);
            if (!found && bus.in_val[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign can_accept = (!val_q || bus.out_rdy) && (|bus.in_val) && !rst;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_rdy
        assign bus.in_rdy[i] = can_accept && (sel == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= 1'b0;
            msg_q <= '0;
            src_q <= '0;
            ptr   <= '0;
        end else if (can_accept) begin
            // Covers both the empty load and the same-edge drain-and-reload.
            val_q <= 1'b1;
            msg_q <= slots[sel];
            src_q <= sel;
            ptr   <= sel + 3'd1;
        end else if (val_q && bus.out_rdy) begin
            val_q <= 1'b0;
        end
    end

    assign bus.out_val   = val_q;
    assign bus.out_msg   = msg_q;
    assign bus.out_src   = src_q;
    assign bus.grant_sel = sel;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed checks of the round-robin arbiter: reset, rotation, wrap,
// back-pressure and mid-operation reset.
module tb_mux8_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter_if #(.p_nbits(32)) bus ();

    mux8_rr_arbiter #(.p_nbits(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic test_reset();
        rst = 1'b1;
        bus.in_val = 8'hFF;
        bus.out_rdy = 1'b1;
        #1;
        total++;
        if (bus.in_rdy !== 8'h00) begin bad++; $display("FAIL rst_in_rdy got %h want 00", bus.in_rdy); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.out_val !== 1'b0) begin bad++; $display("FAIL rst_out_val got %b want 0", bus.out_val); end
        total++;
        if (bus.out_msg !== 32'h0) begin bad++; $display("FAIL rst_out_msg got %h want 0", bus.out_msg); end
        total++;
        if (bus.out_src !== 3'd0) begin bad++; $display("FAIL rst_out_src got %0d want 0", bus.out_src); end
        bus.in_val = 8'h00;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (bus.in_rdy !== 8'h00) begin bad++; $display("FAIL idle_in_rdy c=%0d got %h want 00", c, bus.in_rdy); end
            total++;
            if (bus.grant_sel !== 3'd0) begin bad++; $display("FAIL idle_grant c=%0d got %0d want 0", c, bus.grant_sel); end
            @(negedge clk);
            total++;
            if (bus.out_val !== 1'b0) begin bad++; $display("FAIL idle_out_val c=%0d got %b want 0", c, bus.out_val); end
        end
    endtask

    task automatic test_all_valid();
        logic [2:0] e;
        bus.in_val = 8'hFF;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            e = 3'(c % 8);
            #1;
            total++;
            if (bus.grant_sel !== e) begin bad++; $display("FAIL rr_grant c=%0d got %0d want %0d", c, bus.grant_sel, e); end
            total++;
            if (bus.in_rdy !== (8'h01 << e)) begin bad++; $display("FAIL rr_in_rdy c=%0d got %h want %h", c, bus.in_rdy, 8'h01 << e); end
            @(negedge clk);
            total++;
            if (bus.out_val !== 1'b1 || bus.out_src !== e || bus.out_msg !== 32'hA0 + 32'(e)) begin
                bad++;
                $display("FAIL rr_out c=%0d got val=%b src=%0d msg=%h want val=1 src=%0d msg=%h",
                         c, bus.out_val, bus.out_src, bus.out_msg, e, 32'hA0 + 32'(e));
            end
        end
        // Drain with no new request: entry leaves, contents hold, ptr sits at 2.
        bus.in_val = 8'h00;
        @(negedge clk);
        total++;
        if (bus.out_val !== 1'b0) begin bad++; $display("FAIL drain_val got %b want 0", bus.out_val); end
        total++;
        if (bus.out_src !== 3'd1 || bus.out_msg !== 32'hA1) begin
            bad++; $display("FAIL drain_hold got src=%0d msg=%h want src=1 msg=a1", bus.out_src, bus.out_msg);
        end
        total++;
        if (bus.grant_sel !== 3'd2) begin bad++; $display("FAIL drain_ptr got %0d want 2", bus.grant_sel); end
    endtask

    task automatic test_two_req();
        logic [2:0] e;
        bus.in_val = 8'b1000_0100;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 1) ? 3'd7 : 3'd2;
            #1;
            total++;
            if (bus.grant_sel !== e) begin bad++; $display("FAIL two_grant k=%0d got %0d want %0d", k, bus.grant_sel, e); end
            @(negedge clk);
            total++;
            if (bus.out_val !== 1'b1 || bus.out_src !== e) begin
                bad++; $display("FAIL two_out k=%0d got val=%b src=%0d want val=1 src=%0d", k, bus.out_val, bus.out_src, e);
            end
        end
    endtask

    task automatic test_stall();
        bus.out_rdy = 1'b0;
        bus.in_val = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (bus.in_rdy !== 8'h00) begin bad++; $display("FAIL stall_in_rdy c=%0d got %h want 00", c, bus.in_rdy); end
            total++;
            if (bus.grant_sel !== 3'd0) begin bad++; $display("FAIL stall_grant c=%0d got %0d want 0", c, bus.grant_sel); end
            @(negedge clk);
            total++;
            if (bus.out_val !== 1'b1 || bus.out_src !== 3'd7 || bus.out_msg !== 32'hA7) begin
                bad++; $display("FAIL stall_hold c=%0d got val=%b src=%0d msg=%h want val=1 src=7 msg=a7",
                                c, bus.out_val, bus.out_src, bus.out_msg);
            end
        end
        bus.out_rdy = 1'b1;
        #1;
        total++;
        if (bus.in_rdy !== 8'h01) begin bad++; $display("FAIL unstall_in_rdy got %h want 01", bus.in_rdy); end
        @(negedge clk);
        total++;
        if (bus.out_val !== 1'b1 || bus.out_src !== 3'd0 || bus.out_msg !== 32'hA0) begin
            bad++; $display("FAIL unstall_out got val=%b src=%0d msg=%h want val=1 src=0 msg=a0",
                            bus.out_val, bus.out_src, bus.out_msg);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_val = 8'h20;
        #1;
        total++;
        if (bus.grant_sel !== 3'd5) begin bad++; $display("FAIL single_grant got %0d want 5", bus.grant_sel); end
        @(negedge clk);
        total++;
        if (bus.out_val !== 1'b1 || bus.out_src !== 3'd5) begin
            bad++; $display("FAIL single_out got val=%b src=%0d want val=1 src=5", bus.out_val, bus.out_src);
        end
        rst = 1'b1;
        bus.in_val = 8'h21;
        #1;
        total++;
        if (bus.in_rdy !== 8'h00) begin bad++; $display("FAIL midrst_in_rdy got %h want 00", bus.in_rdy); end
        @(negedge clk);
        total++;
        if (bus.out_val !== 1'b0 || bus.out_src !== 3'd0) begin
            bad++; $display("FAIL midrst_out got val=%b src=%0d want val=0 src=0", bus.out_val, bus.out_src);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.grant_sel !== 3'd0 || bus.in_rdy !== 8'h01) begin
            bad++; $display("FAIL postrst_grant got sel=%0d rdy=%h want sel=0 rdy=01", bus.grant_sel, bus.in_rdy);
        end
        @(negedge clk);
        total++;
        if (bus.out_src !== 3'd0 || bus.out_msg !== 32'hA0) begin
            bad++; $display("FAIL postrst_out got src=%0d msg=%h want src=0 msg=a0", bus.out_src, bus.out_msg);
        end
        #1;
        total++;
        if (bus.grant_sel !== 3'd5) begin bad++; $display("FAIL postrst_next got %0d want 5", bus.grant_sel); end
        @(negedge clk);
        total++;
        if (bus.out_src !== 3'd5 || bus.out_msg !== 32'hA5) begin
            bad++; $display("FAIL postrst_next_out got src=%0d msg=%h want src=5 msg=a5", bus.out_src, bus.out_msg);
        end
    endtask

    initial begin
        logic [8*32-1:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[i*32 +: 32] = 32'hA0 + 32'(i);
        bus.in_msg = m;
        bus.in_val = 8'h00;
        bus.out_rdy = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_all_valid();
        test_two_req();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
